// File: rtl/shift_issue_queue.sv
// shift_issue_queue
//   Request FIFO and registered response stage around the 64-bit barrel
//   shifter. The FIFO head is driven straight onto the shifter inputs; the
//   shifter's combinational result is captured into the response register
//   together with the head tag, which pops the head.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready = !full, registered only)
//   req_in/amt/type/tag      request payload
//   sh_in/sh_amt/sh_type     head entry to the shifter (zero when empty)
//   sh_result                combinational shifter result
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/rsp_tag         registered result and its tag
//   count                    FIFO occupancy, response register excluded
module shift_issue_queue #(
  parameter  int DATA_W = 64,
  parameter  int AMT_W  = 6,
  parameter  int DEPTH  = 4,
  parameter  int TAG_W  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_in,
  input  logic [AMT_W-1:0]  req_amt,
  input  logic [2:0]        req_type,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] sh_in,
  output logic [AMT_W-1:0]  sh_amt,
  output logic [2:0]        sh_type,
  input  logic [DATA_W-1:0] sh_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic [2:0]        typ;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t             mem [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, push, load;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  // Ready comes from the registered count only, so a pop in the same cycle
  // never opens the queue early and there is no path from rsp_ready.
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign load      = !empty && (!rsp_valid || rsp_ready);

  assign head    = mem[rd_ptr];
  assign sh_in   = empty ? '0 : head.data;
  assign sh_amt  = empty ? '0 : head.amt;
  assign sh_type = empty ? '0 : head.typ;

  // Storage is not reset: stale entries are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: req_in, amt: req_amt, typ: req_type, tag: req_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(load);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sh_result;
      rsp_tag   <= head.tag;
    end else if (rsp_valid && rsp_ready) begin
      // Consumed with nothing behind it: drop valid, keep data/tag.
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/shift_issue_queue.md
# shift_issue_queue

Request buffer and result register around the 64-bit barrel shifter. Accepts shift requests (operand, amount, type, tag) on a valid/ready handshake and holds them in a small FIFO. Drives the FIFO head onto the shifter's combinational inputs, captures the shifter result into a registered response stage, and returns it with its tag on a second valid/ready handshake.

## Interface

Parameters:
- DATA_W, 64, operand/result width; fixed at 64 to match the shifter.
- AMT_W, 6, shift amount width, log2(DATA_W).
- DEPTH, 4, FIFO entries; power of two, 2 or more.
- TAG_W, 4, opaque request tag width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept a request.
- req_in  in  DATA_W  operand.
- req_amt  in  AMT_W  shift amount.
- req_type  in  3  shift type code, passed through unchanged.
- req_tag  in  TAG_W  tag.
- sh_in  out  DATA_W  operand to the shifter (head entry).
- sh_amt  out  AMT_W  shift amount to the shifter.
- sh_type  out  3  shift type to the shifter.
- sh_result  in  DATA_W  combinational result from the shifter.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  registered result.
- rsp_tag  out  TAG_W  tag of rsp_data.
- count  out  clog2(DEPTH+1)  FIFO occupancy; excludes the response register.

## Operation

- FIFO state:
  - wr_ptr and rd_ptr are each clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is held in a separate register, 0..DEPTH.
  - empty is count==0; full is count==DEPTH.
- req_ready is !full, taken from registered state only. It has no combinational dependence on rsp_ready or on a pop in the same cycle.
- Push: req_valid && req_ready writes {req_in, req_amt, req_type, req_tag} at wr_ptr, then increments wr_ptr.
- Head drive:
  - When not empty, sh_in/sh_amt/sh_type equal the head entry.
  - When empty, they are all zero.
  - The head is presented without a register stage.
- Response register:
  - load = !empty && (!rsp_valid || rsp_ready).
  - On load: rsp_data <= sh_result, rsp_tag <= head tag, rsp_valid <= 1, and rd_ptr increments (pop).
  - When rsp_valid && rsp_ready && empty: rsp_valid <= 0. rsp_data and rsp_tag hold their values.
  - When rsp_valid && !rsp_ready: rsp_valid, rsp_data and rsp_tag all hold. Nothing pops.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a pop in a cycle does not open req_ready in that same cycle.
- Ordering is strictly FIFO. Responses leave in request order, with no drops and no duplicates.
- Type codes 110/111 are not filtered. The shifter treats them as left-logical.

## Timing

- Reset values: req_ready=1, count=0, rsp_valid=0, rsp_data=0, rsp_tag=0, sh_in=0, sh_amt=0, sh_type=0. Pointers are 0.
- Reset mid-operation discards all queued entries and any pending response. Outputs take the reset values on the edge after rst is sampled high.
- Latency: a request accepted on edge k with the queue empty and rsp idle becomes head after edge k. It is loaded on edge k+1, and rsp_valid=1 follows edge k+1. Minimum latency is 2 cycles.
- Throughput is 1 response per cycle while rsp_ready stays high and requests arrive every cycle.
- While rsp_ready=0, the queue absorbs up to DEPTH further requests, then deasserts req_ready.
- After rsp_ready rises, req_ready reasserts on the edge following the first pop.

## Test plan

- Reset, then push {in=64'h1, amt=4, type=000, tag=3}:
  - rsp_valid rises 2 cycles after acceptance.
  - rsp_data=64'h10, rsp_tag=3.
- Back-to-back types 001, 011, 100, 101, each with in=64'h8000_0000_0000_0001 and amt=1, with rsp_ready=1:
  - Responses, in order: 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 64'h0000_0000_0000_0003, 64'hC000_0000_0000_0000.
  - One response per cycle.
- Hold rsp_ready=0 and push 6 requests:
  - 1 is loaded into the response register and 4 sit in the FIFO.
  - count=4, req_ready=0, and the 6th request is not accepted.
  - rsp_data stays stable for the whole stall.
- From the full state, raise rsp_ready for one cycle:
  - Exactly one pop; count goes to 3.
  - req_ready goes to 1 on the following cycle, not the same one.
  - Tags emerge in push order.
- Assert rst while count=3 and rsp_valid=1:
  - Next cycle: count=0, rsp_valid=0, req_ready=1, sh_in=0.
  - A new request then completes with the 2-cycle latency.
- Send 2*DEPTH+1 requests with random rsp_ready and random req_valid:
  - Pointers wrap correctly.
  - The scoreboard matches every response against a reference shift model.
  - No loss, duplication or reordering.
